// File: rtl/gpio_link_scheduler_pkg.sv
// gpio_link_scheduler_pkg: FSM state encodings, default message width and counter sizing shared by the link logic.
package gpio_link_scheduler_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_t;
  localparam int MSG_W_DEF = 128;
  function automatic int cnt_width(int a, int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/gpio_link_scheduler_if.sv
// gpio_link_scheduler_if: requester, link and rx-buffer signals of the scheduler; master is the scheduler side.
interface gpio_link_scheduler_if #(parameter int NUM_REQ = 4, parameter int MSG_W = 128);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*MSG_W-1:0] req_msg;
  logic [NUM_REQ-1:0] req_ack;
  logic link_data_ready;
  logic [MSG_W-1:0] link_message_out;
  logic link_done;
  logic link_received;
  logic [MSG_W-1:0] link_message_in;
  logic rx_valid;
  logic [MSG_W-1:0] rx_msg;
  logic rx_ready;
  logic rx_overflow;
  logic busy;
  logic tx_timeout;
  modport master (
    input  req, req_msg, link_done, link_received, link_message_in, rx_ready,
    output req_ack, link_data_ready, link_message_out, rx_valid, rx_msg, rx_overflow, busy, tx_timeout
  );
  modport slave (
    output req, req_msg, link_done, link_received, link_message_in, rx_ready,
    input  req_ack, link_data_ready, link_message_out, rx_valid, rx_msg, rx_overflow, busy, tx_timeout
  );
endinterface

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: 2-flop synchronizer followed by a rising-edge pulse, asynchronously cleared by resetn.
module gpio_sync_edge (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic pulse
);
  logic [2:0] s_q, s_d;
  always_comb s_d = {s_q[1:0], d};
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) s_q <= '0;
    else s_q <= s_d;
  assign pulse = s_q[1] & ~s_q[2];
endmodule

// File: rtl/gpio_link_scheduler.sv
// gpio_link_scheduler: round-robin sharing of the GPIO message link plus a one-entry inbound buffer.
// Optional send abort is enabled by defining GPIO_LINK_TIMEOUT_EN.
module gpio_link_scheduler
  import gpio_link_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MSG_W       = MSG_W_DEF,
  parameter int IDLE_GAP    = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic clock,
  input logic resetn,
  gpio_link_scheduler_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(TIMEOUT_CYC, IDLE_GAP);
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, ptr_q, ptr_d, pick;
  logic [MSG_W-1:0] msg_q, msg_d, rx_msg_q, rx_msg_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dr_q, dr_d, to_q, to_d, rx_valid_q, rx_valid_d, ovf_q, ovf_d;
  logic done_p, rx_p, launch;
  gpio_sync_edge u_done (.clock(clock), .resetn(resetn), .d(bus.link_done), .pulse(done_p));
  gpio_sync_edge u_rx (.clock(clock), .resetn(resetn), .d(bus.link_received), .pulse(rx_p));
  // Descending scan so the nearest set bit after the pointer is written last and wins.
  always_comb begin
    pick = ptr_q;
    for (int i = NUM_REQ; i >= 1; i--)
      if (bus.req[IW'((int'(ptr_q) + i) % NUM_REQ)]) pick = IW'((int'(ptr_q) + i) % NUM_REQ);
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    msg_d   = msg_q;
    dr_d    = dr_q;
    ack_d   = '0;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE: launch = |bus.req;
      ST_SEND: begin
        if (done_p) begin
          ack_d[grant_q] = 1'b1;
          dr_d    = 1'b0;
          ptr_d   = grant_q;
          cnt_d   = '0;
          state_d = ST_GAP;
        end
`ifdef GPIO_LINK_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          to_d    = 1'b1;
          dr_d    = 1'b0;
          ptr_d   = grant_q;
          cnt_d   = '0;
          state_d = ST_GAP;
        end
        else cnt_d = cnt_q + CW'(1);
`endif
      end
      ST_GAP: begin
        // Last gap cycle may launch directly so data_ready is low exactly IDLE_GAP clocks.
        if (cnt_q == CW'(IDLE_GAP - 1)) begin
          state_d = ST_IDLE;
          launch  = |bus.req;
        end
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (launch) begin
      grant_d = pick;
      msg_d   = bus.req_msg[pick*MSG_W +: MSG_W];
      dr_d    = 1'b1;
      cnt_d   = '0;
      state_d = ST_SEND;
    end
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      msg_q   <= '0;
      dr_q    <= 1'b0;
      ack_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      msg_q   <= msg_d;
      dr_q    <= dr_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  // Capture wins over a same-cycle pop; a full, unpopped buffer drops the new message.
  always_comb begin
    rx_msg_d   = rx_msg_q;
    rx_valid_d = rx_valid_q & ~bus.rx_ready;
    ovf_d      = ovf_q;
    if (rx_p) begin
      rx_msg_d   = (!rx_valid_q || bus.rx_ready) ? bus.link_message_in : rx_msg_q;
      rx_valid_d = 1'b1;
      ovf_d      = ovf_q | (rx_valid_q & ~bus.rx_ready);
    end
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      rx_msg_q   <= '0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_msg_q   <= rx_msg_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
    end
  assign bus.req_ack          = ack_q;
  assign bus.link_data_ready  = dr_q;
  assign bus.link_message_out = msg_q;
  assign bus.rx_valid         = rx_valid_q;
  assign bus.rx_msg           = rx_msg_q;
  assign bus.rx_overflow      = ovf_q;
  assign bus.busy             = state_q != ST_IDLE;
`ifdef GPIO_LINK_TIMEOUT_EN
  assign bus.tx_timeout       = to_q;
`else
  assign bus.tx_timeout       = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_link_scheduler.sv
// tb_gpio_link_scheduler: directed stimulus with a queue scoreboard checked by a separate monitor process.
module tb_gpio_link_scheduler;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] msg_exp[$];
  int ack_exp[$];
  logic [127:0] rx_exp[$];
  gpio_link_scheduler_if #(.NUM_REQ(4), .MSG_W(128)) bus ();
  gpio_link_scheduler #(.NUM_REQ(4), .MSG_W(128), .IDLE_GAP(2), .TIMEOUT_CYC(16)) dut (
    .clock(clock), .resetn(resetn), .bus(bus.master)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clock);
    #1;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    bus.req = '0;
    bus.link_done = 1'b0;
    bus.link_received = 1'b0;
    bus.rx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ack", bus.req_ack, 0);
    chk("rst_dr", bus.link_data_ready, 0);
    chk("rst_msg", bus.link_message_out, 0);
    chk("rst_rxv", bus.rx_valid, 0);
    chk("rst_rxmsg", bus.rx_msg, 0);
    chk("rst_ovf", bus.rx_overflow, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_to", bus.tx_timeout, 0);
    resetn = 1'b1;
    tick();
  endtask
  task automatic wait_dr();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.link_data_ready && n < 50);
    chk("dr_wait", bus.link_data_ready, 1);
  endtask
  task automatic do_done(input int idx);
    int lat = 0;
    bus.link_done = 1'b0;
    repeat (3) tick();
    ack_exp.push_back(idx);
    bus.link_done = 1'b1;
    do begin
      tick();
      lat++;
    end while (bus.req_ack == 0 && lat < 10);
    chk("done_lat", lat, 3);
    bus.link_done = 1'b0;
  endtask
  task automatic rx_edge(input logic [127:0] m);
    bus.link_message_in = m;
    bus.link_received = 1'b1;
    repeat (4) tick();
    bus.link_received = 1'b0;
    repeat (3) tick();
  endtask
  // Monitor: samples after the driver has settled each cycle.
  initial begin
    logic prev_dr = 1'b0;
    logic [3:0] prev_ack = '0;
    forever begin
      @(negedge clock);
      #2;
      if (!resetn) begin
        prev_dr = 1'b0;
        prev_ack = '0;
      end else begin
        if (bus.link_data_ready && !prev_dr) begin
          if (msg_exp.size() == 0) chk("tx_unexpected", 1, 0);
          else chk("tx_msg", bus.link_message_out, msg_exp.pop_front());
        end
        if (bus.req_ack != 0) begin
          if (ack_exp.size() == 0) chk("ack_unexpected", bus.req_ack, 0);
          else chk("ack_grant", bus.req_ack, 128'(4'b1 << ack_exp.pop_front()));
          chk("ack_dr_low", bus.link_data_ready, 0);
          chk("ack_width", prev_ack, 0);
        end
        if (bus.rx_valid && bus.rx_ready) begin
          if (rx_exp.size() == 0) chk("rx_unexpected", 1, 0);
          else chk("rx_pop", bus.rx_msg, rx_exp.pop_front());
        end
        prev_dr = bus.link_data_ready;
        prev_ack = bus.req_ack;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int gap;
    bus.req = '0;
    bus.req_msg = '0;
    bus.link_done = 1'b0;
    bus.link_received = 1'b0;
    bus.link_message_in = '0;
    bus.rx_ready = 1'b0;
    // Single requester: data_ready and message on the next cycle, ack 3 clocks after done.
    do_reset();
    bus.req_msg = {128'h0, 128'h0, 128'h0, 128'h1};
    bus.req = 4'b0001;
    msg_exp.push_back(128'h1);
    tick();
    chk("t1_dr", bus.link_data_ready, 1);
    chk("t1_msg", bus.link_message_out, 128'h1);
    chk("t1_busy", bus.busy, 1);
    do_done(0);
    bus.req = '0;
    tick();
    chk("t1_gap_dr", bus.link_data_ready, 0);
    chk("t1_gap_busy", bus.busy, 1);
    tick();
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_dr", bus.link_data_ready, 0);
    // All requesting: round-robin 0,1,2,3,0 with a 2-cycle data_ready gap.
    do_reset();
    bus.req_msg = {128'h103, 128'h102, 128'h101, 128'h100};
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) msg_exp.push_back(128'h100 + 128'(k % 4));
    for (int k = 0; k < 5; k++) begin
      wait_dr();
      do_done(k % 4);
      if (k == 4) bus.req = '0;
      else begin
        gap = 1;
        tick();
        while (!bus.link_data_ready && gap < 10) begin
          gap++;
          tick();
        end
        chk("t2_gap", gap, 2);
      end
    end
    repeat (4) tick();
    chk("t2_idle", bus.busy, 0);
    // RX capture then overflow without pop.
    do_reset();
    rx_exp.push_back(128'hDEAD_BEEF);
    rx_edge(128'hDEAD_BEEF);
    chk("t3_rxv", bus.rx_valid, 1);
    chk("t3_rxmsg", bus.rx_msg, 128'hDEAD_BEEF);
    chk("t3_ovf0", bus.rx_overflow, 0);
    rx_edge(128'h5);
    chk("t3_ovf1", bus.rx_overflow, 1);
    chk("t3_keep", bus.rx_msg, 128'hDEAD_BEEF);
    chk("t3_rxv2", bus.rx_valid, 1);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    chk("t3_popped", bus.rx_valid, 0);
    chk("t3_sticky", bus.rx_overflow, 1);
    // Pop in the same cycle as a capture: new value kept, no overflow.
    do_reset();
    rx_exp.push_back(128'hAA);
    rx_edge(128'hAA);
    bus.link_message_in = 128'hBB;
    bus.link_received = 1'b1;
    repeat (2) tick();
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    chk("t4_rxv", bus.rx_valid, 1);
    chk("t4_rxmsg", bus.rx_msg, 128'hBB);
    chk("t4_ovf", bus.rx_overflow, 0);
    bus.link_received = 1'b0;
    repeat (3) tick();
    rx_exp.push_back(128'hBB);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    chk("t4_empty", bus.rx_valid, 0);
    // Reset mid-send to requester 2, then requester 0 wins after release.
    do_reset();
    bus.req_msg = {128'h103, 128'h102, 128'h101, 128'h100};
    bus.req = 4'b0100;
    msg_exp.push_back(128'h102);
    wait_dr();
    repeat (2) tick();
    resetn = 1'b0;
    #1;
    chk("t5_dr", bus.link_data_ready, 0);
    chk("t5_msg", bus.link_message_out, 0);
    chk("t5_busy", bus.busy, 0);
    tick();
    bus.req = 4'b0101;
    msg_exp.push_back(128'h100);
    resetn = 1'b1;
    wait_dr();
    do_done(0);
    bus.req = '0;
    repeat (4) tick();
    // Send without done: timeout when enabled, otherwise waits indefinitely.
    do_reset();
    bus.req = 4'b0001;
    msg_exp.push_back(128'h100);
    wait_dr();
`ifdef GPIO_LINK_TIMEOUT_EN
    begin
      int n = 0;
      do begin
        tick();
        n++;
      end while (!bus.tx_timeout && n < 40);
      chk("t6_to_lat", n, 16);
      chk("t6_ack", bus.req_ack, 0);
      chk("t6_dr", bus.link_data_ready, 0);
      bus.req = '0;
      tick();
      chk("t6_to_pulse", bus.tx_timeout, 0);
    end
`else
    begin
      int bad = 0;
      repeat (2000) begin
        tick();
        if (!bus.link_data_ready || !bus.busy || bus.tx_timeout || bus.req_ack != 0) bad++;
      end
      chk("t6_hold", bad, 0);
      do_done(0);
      bus.req = '0;
    end
`endif
    repeat (6) tick();
    chk("q_tx_empty", msg_exp.size(), 0);
    chk("q_ack_empty", ack_exp.size(), 0);
    chk("q_rx_empty", rx_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
